// File: rtl/vga_pkg.sv
// Shared 1024x768 raster timing constants for the VGA sync generator and the
// text console that consumes its beam position.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 1024;
    localparam int VGA_H_FP      = 24;
    localparam int VGA_H_SYNC    = 136;
    localparam int VGA_H_BP      = 160;
    localparam int VGA_V_VISIBLE = 768;
    localparam int VGA_V_FP      = 3;
    localparam int VGA_V_SYNC    = 6;
    localparam int VGA_V_BP      = 29;
    localparam int VGA_Y_BLK     = 48;

    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_HS_START  = VGA_H_VISIBLE + VGA_H_FP;
    localparam int VGA_HS_END    = VGA_HS_START + VGA_H_SYNC;
    localparam int VGA_VS_START  = VGA_V_VISIBLE + VGA_V_FP;
    localparam int VGA_VS_END    = VGA_VS_START + VGA_V_SYNC;

    localparam int X_BLK  = 32;
    localparam int X_LO_W = 5;
    localparam int X_HI_W = 6;
    localparam int Y_LO_W = 6;
    localparam int Y_HI_W = 5;

    // Compares a split (hi, lo) line number against a split constant without
    // rebuilding y = hi*Y_BLK + lo.
    function automatic logic split_ge(input logic [Y_HI_W-1:0] hi,
                                      input logic [Y_LO_W-1:0] lo,
                                      input logic [Y_HI_W-1:0] c_hi,
                                      input logic [Y_LO_W-1:0] c_lo);
        return (hi > c_hi) || ((hi == c_hi) && (lo >= c_lo));
    endfunction

endpackage

// File: rtl/vga_block_counter.sv
// Two-field counter: lo counts modulo LO_MOD and carries into hi; clear wins
// over increment.
module vga_block_counter #(
    parameter int LO_MOD = 32,
    parameter int LO_W   = 5,
    parameter int HI_W   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            clr_i,
    output logic [LO_W-1:0] lo_o,
    output logic [HI_W-1:0] hi_o,
    output logic            tc_o
);

    logic [LO_W-1:0] lo_q, lo_d;
    logic [HI_W-1:0] hi_q, hi_d;

    assign tc_o = (lo_q == LO_W'(LO_MOD - 1));

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (clr_i) begin
            lo_d = '0;
            hi_d = '0;
        end else if (inc_i) begin
            if (tc_o) begin
                lo_d = '0;
                hi_d = hi_q + HI_W'(1);
            end else begin
                lo_d = lo_q + LO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign lo_o = lo_q;
    assign hi_o = hi_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running raster timing generator: split beam position, blank, registered
// active-low syncs and a sticky vertical-blank interrupt.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int Y_BLK     = VGA_Y_BLK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cli,
    output logic [X_LO_W-1:0] x_lo,
    output logic [X_HI_W-1:0] x_hi,
    output logic [Y_LO_W-1:0] y_lo,
    output logic [Y_HI_W-1:0] y_hi,
    output logic              blank,
    output logic              hsync,
    output logic              vsync,
    output logic              interrupt
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int X_W      = X_HI_W + X_LO_W;

    // Block-aligned limits let blank and end-of-line decode from hi fields alone.
    if (H_TOTAL > 2048)              begin : g_chk_htot  $error("H_TOTAL exceeds 2048"); end
    if (V_TOTAL > 32 * Y_BLK)        begin : g_chk_vtot  $error("V_TOTAL exceeds 32*Y_BLK"); end
    if (Y_BLK > 64)                  begin : g_chk_yblk  $error("Y_BLK exceeds 64"); end
    if (H_TOTAL % X_BLK != 0)        begin : g_chk_hal   $error("H_TOTAL not a multiple of 32"); end
    if (H_VISIBLE % X_BLK != 0)      begin : g_chk_hvis  $error("H_VISIBLE not a multiple of 32"); end
    if (V_VISIBLE % Y_BLK != 0)      begin : g_chk_vvis  $error("V_VISIBLE not a multiple of Y_BLK"); end

    logic           x_tc, y_tc, x_end, y_last, vis_last;
    logic [X_W-1:0] x_pos;
    logic           hsync_q, hsync_d, vsync_q, vsync_d, irq_q, irq_d;

    vga_block_counter #(.LO_MOD(X_BLK), .LO_W(X_LO_W), .HI_W(X_HI_W)) u_x_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (1'b1),
        .clr_i (x_end),
        .lo_o  (x_lo),
        .hi_o  (x_hi),
        .tc_o  (x_tc)
    );

    vga_block_counter #(.LO_MOD(Y_BLK), .LO_W(Y_LO_W), .HI_W(Y_HI_W)) u_y_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (x_end),
        .clr_i (x_end && y_last),
        .lo_o  (y_lo),
        .hi_o  (y_hi),
        .tc_o  (y_tc)
    );

    assign x_pos    = {x_hi, x_lo};
    assign x_end    = x_tc && (x_hi == X_HI_W'(H_TOTAL / X_BLK - 1));
    assign y_last   = (y_hi == Y_HI_W'((V_TOTAL - 1) / Y_BLK)) &&
                      (y_lo == Y_LO_W'((V_TOTAL - 1) % Y_BLK));
    assign vis_last = y_tc && (y_hi == Y_HI_W'(V_VISIBLE / Y_BLK - 1));
    assign blank    = (x_hi >= X_HI_W'(H_VISIBLE / X_BLK)) ||
                      (y_hi >= Y_HI_W'(V_VISIBLE / Y_BLK));

    always_comb begin
        hsync_d = !((x_pos >= X_W'(HS_START)) && (x_pos < X_W'(HS_END)));
        vsync_d = !(split_ge(y_hi, y_lo, Y_HI_W'(VS_START / Y_BLK), Y_LO_W'(VS_START % Y_BLK)) &&
                    !split_ge(y_hi, y_lo, Y_HI_W'(VS_END / Y_BLK), Y_LO_W'(VS_END % Y_BLK)));
        irq_d   = irq_q;
        if (x_end && vis_last) begin
            irq_d = 1'b1;
        end else if (cli) begin
            irq_d = 1'b0;
        end
    end

    // Syncs lag the counters by one cycle to line up with the registered RGB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            irq_q   <= irq_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: one full-timing instance and one shrunken-timing instance so
// whole frames fit in a short run; both checked every cycle against a counter model.
module tb_vga_sync_gen;

    localparam int FH_TOT = 1344;
    localparam int FV_TOT = 806;
    localparam int SH_TOT = 96;
    localparam int SV_TOT = 12;
    localparam int S_FRAME = SH_TOT * SV_TOT;
    localparam logic [31:0] RST_VEC = 32'h0000_0006;

    logic clk = 1'b0;
    logic rst;
    logic cli;
    always #5 clk = ~clk;

    logic [4:0] f_x_lo, s_x_lo;
    logic [5:0] f_x_hi, s_x_hi;
    logic [5:0] f_y_lo, s_y_lo;
    logic [4:0] f_y_hi, s_y_hi;
    logic f_blank, f_hsync, f_vsync, f_irq;
    logic s_blank, s_hsync, s_vsync, s_irq;

    vga_sync_gen dut_full (
        .clk(clk), .rst(rst), .cli(cli),
        .x_lo(f_x_lo), .x_hi(f_x_hi), .y_lo(f_y_lo), .y_hi(f_y_hi),
        .blank(f_blank), .hsync(f_hsync), .vsync(f_vsync), .interrupt(f_irq)
    );

    vga_sync_gen #(
        .H_VISIBLE(64), .H_FP(8), .H_SYNC(16), .H_BP(8),
        .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .Y_BLK(4)
    ) dut_small (
        .clk(clk), .rst(rst), .cli(cli),
        .x_lo(s_x_lo), .x_hi(s_x_hi), .y_lo(s_y_lo), .y_hi(s_y_hi),
        .blank(s_blank), .hsync(s_hsync), .vsync(s_vsync), .interrupt(s_irq)
    );

    logic [31:0] f_vec, s_vec;
    assign f_vec = {6'd0, f_x_hi, f_x_lo, f_y_hi, f_y_lo, f_blank, f_hsync, f_vsync, f_irq};
    assign s_vec = {6'd0, s_x_hi, s_x_lo, s_y_hi, s_y_lo, s_blank, s_hsync, s_vsync, s_irq};

    int compared = 0;
    int mismatched = 0;

    int   c;
    logic fhs, fvs, shs, svs, sirq;
    int   hs_low, hs_first, vs_low, zero_hits, zprev, zlast, rises, irq_gaps;
    logic irq_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_vec(input int x, input int y, input int yb,
                                              input int hvis, input int vvis,
                                              input logic hs, input logic vs, input logic irq);
        logic bl;
        bl = (x >= hvis) || (y >= vvis);
        return {6'd0, 6'(x / 32), 5'(x % 32), 5'(y / yb), 6'(y % yb), bl, hs, vs, irq};
    endfunction

    task automatic step();
        int fx, fy, sx, sy;
        logic cli_at_edge;
        fx = c % FH_TOT;
        fy = (c / FH_TOT) % FV_TOT;
        sx = c % SH_TOT;
        sy = (c / SH_TOT) % SV_TOT;
        @(posedge clk);
        cli_at_edge = cli;
        #1;
        fhs = !(fx >= 1048 && fx < 1184);
        fvs = !(fy >= 771 && fy < 777);
        shs = !(sx >= 72 && sx < 88);
        svs = !(sy >= 9 && sy < 11);
        c++;
        if ((c % S_FRAME) == 8 * SH_TOT) sirq = 1'b1;
        else if (cli_at_edge)            sirq = 1'b0;
        check("full_raster", f_vec,
              model_vec(c % FH_TOT, (c / FH_TOT) % FV_TOT, 48, 1024, 768, fhs, fvs, 1'b0));
        check("small_raster", s_vec,
              model_vec(c % SH_TOT, (c / SH_TOT) % SV_TOT, 4, 64, 8, shs, svs, sirq));
    endtask

    task automatic run_to(input int target);
        while (c < target) begin
            cli = (c == 3199) || (c == 4223) || (c == 4299) || (c == 4400);
            step();
            if (c <= FH_TOT && f_hsync == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = 32'({f_x_hi, f_x_lo});
            end
            if (c <= S_FRAME && s_vsync == 1'b0) vs_low++;
            if (c <= 2400 && {s_x_hi, s_x_lo, s_y_hi, s_y_lo} == 22'd0) begin
                zero_hits++;
                zprev = zlast;
                zlast = c;
            end
            if (c < 3200 && s_irq && !irq_prev) rises++;
            if (c >= 768 && c < 3200 && !s_irq) irq_gaps++;
            irq_prev = s_irq;
        end
        cli = 1'b0;
    endtask

    task automatic model_reset();
        c = 0; fhs = 1'b1; fvs = 1'b1; shs = 1'b1; svs = 1'b1; sirq = 1'b0; irq_prev = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cli = 1'b0;
        model_reset();
        hs_low = 0; hs_first = -1; vs_low = 0; zero_hits = 0; zprev = 0; zlast = 0;
        rises = 0; irq_gaps = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_full", f_vec, RST_VEC);
        check("reset_small", s_vec, RST_VEC);
        @(negedge clk);
        rst = 1'b0;

        run_to(1);
        check("first_x_after_reset", 32'({f_x_hi, f_x_lo, f_y_hi, f_y_lo}), 32'({6'd0, 5'd1, 5'd0, 6'd0}));

        run_to(768);
        check("vblank_entry", 32'({s_x_hi, s_x_lo, s_y_hi, s_y_lo, s_blank, s_irq}),
              32'({6'd0, 5'd0, 5'd2, 6'd0, 1'b1, 1'b1}));

        run_to(FH_TOT);
        check("line_wrap", 32'({f_x_hi, f_x_lo, f_y_hi, f_y_lo}), 32'({6'd0, 5'd0, 5'd0, 6'd1}));
        check("hsync_low_cycles", hs_low, 136);
        check("hsync_first_low_x", hs_first, 1049);

        run_to(2400);
        check("frame_zero_hits", zero_hits, 2);
        check("frame_period", zlast - zprev, S_FRAME);
        check("vsync_low_cycles", vs_low, 192);

        run_to(3199);
        check("irq_sticky_3_frames", s_irq, 1);
        check("irq_single_rise", rises, 1);
        check("irq_no_glitch", irq_gaps, 0);

        run_to(3200);
        check("cli_clears", s_irq, 0);
        run_to(4224);
        check("cli_on_set_edge", s_irq, 1);
        run_to(4300);
        check("cli_clears_again", s_irq, 0);
        run_to(4401);
        check("cli_when_clear", s_irq, 0);
        check("full_irq_idle", f_irq, 0);

        run_to(48 * FH_TOT - 1);
        check("y_lo_47", 32'({f_y_hi, f_y_lo}), 32'({5'd0, 6'd47}));
        run_to(48 * FH_TOT);
        check("yblk_wrap", 32'({f_x_hi, f_x_lo, f_y_hi, f_y_lo}), 32'({6'd0, 5'd0, 5'd1, 6'd0}));

        run_to(48 * FH_TOT + 700);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_full", f_vec, RST_VEC);
        check("async_reset_small", s_vec, RST_VEC);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held_full", f_vec, RST_VEC);
        check("reset_held_small", s_vec, RST_VEC);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_to(1);
        check("restart_x_full", 32'({f_x_hi, f_x_lo, f_y_hi, f_y_lo}), 32'({6'd0, 5'd1, 5'd0, 6'd0}));
        check("restart_x_small", 32'({s_x_hi, s_x_lo, s_y_hi, s_y_lo}), 32'({6'd0, 5'd1, 5'd0, 6'd0}));
        run_to(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
